// File: rtl/serial_addsub_unit_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package serial_addsub_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic bit width_ok(input int w, input int d);
    return (d >= 1) && (d <= w) && ((w % d) == 0);
  endfunction

endpackage

// File: rtl/serial_addsub_unit_adder.sv
// DIGIT-bit ripple slice built from full adders; also exposes the carry
// into its top bit so the caller can derive signed overflow.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

module ripple_digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             cout_o,
  output logic             ctop_o
);

  logic [DIGIT:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a_i  (a_i[i]),
      .b_i  (b_i[i]),
      .ci_i (c[i]),
      .s_o  (sum_o[i]),
      .co_o (c[i+1])
    );
  end

  assign cout_o = c[DIGIT];
  assign ctop_o = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub_unit.sv
// Digit-serial adder/subtractor: WIDTH bits in WIDTH/DIGIT cycles through
// one ripple slice, with valid/ready handshakes on both sides.
module serial_addsub_unit
  import serial_addsub_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             carry,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_cfg
    $error("WIDTH must be a positive multiple of DIGIT");
  end

  state_e           state_q;
  logic [WIDTH-1:0] xa_q;
  logic [WIDTH-1:0] yb_q;
  logic [WIDTH-1:0] z_sh_q;
  logic [WIDTH-1:0] z_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic             carry_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [DIGIT-1:0]       sum;
  logic                   cout;
  logic                   ctop;
  logic                   last;
  logic [WIDTH+DIGIT-1:0] zcat;
  logic [WIDTH-1:0]       z_sh_d;
  logic [WIDTH-1:0]       xa_d;
  logic [WIDTH-1:0]       yb_d;

  ripple_digit_adder #(
    .DIGIT (DIGIT)
  ) u_slice (
    .a_i    (xa_q[DIGIT-1:0]),
    .b_i    (yb_q[DIGIT-1:0]),
    .cin_i  (c_q),
    .sum_o  (sum),
    .cout_o (cout),
    .ctop_o (ctop)
  );

  // Sum digits enter at the MSB end; after N shifts the LSB digit lands at bit 0.
  assign zcat   = {sum, z_sh_q};
  assign z_sh_d = zcat[WIDTH+DIGIT-1:DIGIT];
  assign xa_d   = xa_q >> DIGIT;
  assign yb_d   = yb_q >> DIGIT;
  assign last   = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      xa_q        <= '0;
      yb_q        <= '0;
      z_sh_q      <= '0;
      z_q         <= '0;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            xa_q       <= x;
            yb_q       <= sub ? ~y : y;
            c_q        <= sub;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          xa_q   <= xa_d;
          yb_q   <= yb_d;
          z_sh_q <= z_sh_d;
          c_q    <= cout;
          cnt_q  <= cnt_q + CW'(1);
          if (last) begin
            z_q         <= z_sh_d;
            carry_q     <= cout;
            ovf_q       <= ctop ^ cout;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Directed bench: three instances (DIGIT=4, 16, 1) share stimulus and are
// checked against a hand-computed vector table plus reset/backpressure cases.
module tb_serial_addsub_unit;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        sub;
    logic [15:0] ez;
    logic        ec;
    logic        eo;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] x = '0;
  logic [15:0] y = '0;

  logic        ir [3];
  logic        ovl[3];
  logic        cy [3];
  logic        of [3];
  logic [15:0] z  [3];

  int   ncyc[3];
  int   n_run = 0;
  int   n_fail = 0;
  vec_t vecs[8];

  always #5 clk = ~clk;

  serial_addsub_unit #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(ir[0]), .x(x), .y(y), .sub(sub),
    .out_valid(ovl[0]), .out_ready(out_ready),
    .z(z[0]), .carry(cy[0]), .overflow(of[0])
  );

  serial_addsub_unit #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(ir[1]), .x(x), .y(y), .sub(sub),
    .out_valid(ovl[1]), .out_ready(out_ready),
    .z(z[1]), .carry(cy[1]), .overflow(of[1])
  );

  serial_addsub_unit #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(ir[2]), .x(x), .y(y), .sub(sub),
    .out_valid(ovl[2]), .out_ready(out_ready),
    .z(z[2]), .carry(cy[2]), .overflow(of[2])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [15:0] ez,
                         input logic ec, input logic eo,
                         input logic ev, input logic er);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_d%0d_z", nm, k), 32'(z[k]), 32'(ez));
      chk($sformatf("%s_d%0d_carry", nm, k), 32'(cy[k]), 32'(ec));
      chk($sformatf("%s_d%0d_ovf", nm, k), 32'(of[k]), 32'(eo));
      chk($sformatf("%s_d%0d_ovalid", nm, k), 32'(ovl[k]), 32'(ev));
      chk($sformatf("%s_d%0d_iready", nm, k), 32'(ir[k]), 32'(er));
    end
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic s);
    int k;
    k = 0;
    while (!(ir[0] && ir[1] && ir[2]) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("accept_ready", 32'(ir[0] && ir[1] && ir[2]), 32'd1);
    x = a; y = b; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = 16'($urandom);
    y = 16'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic collect(input string nm, input logic [15:0] ez,
                         input logic ec, input logic eo);
    int lat[3];
    lat = '{0, 0, 0};
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++)
        if (ovl[k] && lat[k] == 0) lat[k] = cyc;
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s_d%0d_latency", nm, k), 32'(lat[k]), 32'(ncyc[k]));
    chk_out(nm, ez, ec, eo, 1'b1, 1'b0);
  endtask

  task automatic release_out(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_rel_d%0d_ovalid", nm, k), 32'(ovl[k]), 32'd0);
      chk($sformatf("%s_rel_d%0d_iready", nm, k), 32'(ir[k]), 32'd1);
    end
  endtask

  initial begin
    ncyc = '{4, 1, 16};
    vecs[0] = '{16'h1234, 16'h0fff, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hffff, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7fff, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h7fff, 16'hffff, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7fff, 1'b1, 1'b1};
    vecs[6] = '{16'h0000, 16'h0001, 1'b1, 16'hffff, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

    // Reset held across edges
    #12;
    chk_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].x, vecs[i].y, vecs[i].sub);
      collect($sformatf("vec%0d", i), vecs[i].ez, vecs[i].ec, vecs[i].eo);
      release_out($sformatf("vec%0d", i));
    end

    // Backpressure with a competing request in DONE
    start_op(16'h1234, 16'h0fff, 1'b0);
    collect("bp", 16'h2233, 1'b0, 1'b0);
    x = 16'h0005; y = 16'h0003; sub = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk_out($sformatf("bp_hold%0d", c), 16'h2233, 1'b0, 1'b0,
              1'b1, 1'b0);
    end
    release_out("bp");
    start_op(16'h0005, 16'h0003, 1'b1);
    collect("bp_next", 16'h0002, 1'b1, 1'b0);
    release_out("bp_next");

    // Asynchronous reset in DONE clears outputs without a clock edge
    start_op(16'h7fff, 16'h0001, 1'b0);
    collect("arst_pre", 16'h8000, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_out("arst_done", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the second RUN cycle, then a clean operation
    start_op(16'h7fff, 16'hffff, 1'b1);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("rrun_ovalid", 32'(ovl[0]), 32'd0);
    chk("rrun_iready", 32'(ir[0]), 32'd1);
    chk("rrun_z", 32'(z[0]), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(16'h1234, 16'h0fff, 1'b0);
    collect("rrun_after", 16'h2233, 1'b0, 1'b0);
    release_out("rrun_after");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
